// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and types for the multi-digit BCD up/down counter.
//   BCD_BIT_WIDTH : bits per BCD digit
//   BCD_MAX       : largest legal BCD digit value
//   cnt_state_t   : run/pause/clear control FSM state encoding
//   clamp_digit() : saturates a 4-bit nibble into the legal BCD range 0..9
package bcd_updown_counter_pkg;

    localparam int          BCD_BIT_WIDTH = 4;
    localparam logic [3:0]  BCD_MAX       = 4'd9;

    typedef enum logic [1:0] {
        CNT_IDLE  = 2'd0,
        CNT_RUN   = 2'd1,
        CNT_PAUSE = 2'd2
    } cnt_state_t;

    function automatic logic [BCD_BIT_WIDTH-1:0] clamp_digit(input logic [BCD_BIT_WIDTH-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// Combinational single-digit BCD step.
//   value    : current digit value (0..9)
//   en       : carry/borrow in; the digit steps only when high
//   dir      : 0 = increment, 1 = decrement
//   lim      : clamped limit digit at this position
//   next     : digit value after the step
//   carry    : carry out (up, 9 -> 0) or borrow out (down, 0 -> 9)
//   at_bound : up: digit equals its limit digit; down: digit is zero
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic [BCD_BIT_WIDTH-1:0] value,
    input  logic                     en,
    input  logic                     dir,
    input  logic [BCD_BIT_WIDTH-1:0] lim,
    output logic [BCD_BIT_WIDTH-1:0] next,
    output logic                     carry,
    output logic                     at_bound
);

    always_comb begin
        next  = value;
        carry = 1'b0;
        if (en) begin
            if (!dir) begin
                if (value >= BCD_MAX) begin
                    next  = '0;
                    carry = 1'b1;
                end else begin
                    next = value + 4'd1;
                end
            end else begin
                if (value == '0) begin
                    next  = BCD_MAX;
                    carry = 1'b1;
                end else begin
                    next = value - 4'd1;
                end
            end
        end
    end

    assign at_bound = dir ? (value == '0) : (value == lim);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with run/pause/clear control.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   tick           : one-cycle count strobe
//   pb_start       : one-pulse, toggles run/pause
//   pb_clear       : one-pulse, reloads the start value and stops
//   mode_selection : 0 = count up, 1 = count down
//   limit          : packed BCD upper bound (digits clamped to 9)
//   count          : packed BCD count, digit 0 least significant
//   running        : high while in RUN
//   wrap           : one-cycle pulse on wrap-around
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    input  logic                            pb_start,
    input  logic                            pb_clear,
    input  logic                            mode_selection,
    input  logic [BCD_BIT_WIDTH*DIGITS-1:0] limit,
    output logic [BCD_BIT_WIDTH*DIGITS-1:0] count,
    output logic                            running,
    output logic                            wrap
);

    localparam int W = BCD_BIT_WIDTH * DIGITS;

    cnt_state_t    state;
    logic [W-1:0]  lim_c;
    logic [W-1:0]  start_val;
    logic [W-1:0]  step_val;
    logic [DIGITS:0]   chain;
    logic [DIGITS-1:0] at_bound;
    logic          up_wrap;
    logic          down_zero;
    logic          above_lim;

    // The digit chain always receives a carry-in at digit 0: a tick is
    // exactly one unit step, propagated upward by carry/borrow.
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign lim_c[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] =
            clamp_digit(limit[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]);

        bcd_digit u_digit (
            .value    (count[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
            .en       (chain[g]),
            .dir      (mode_selection),
            .lim      (lim_c[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
            .next     (step_val[g*BCD_BIT_WIDTH +: BCD_BIT_WIDTH]),
            .carry    (chain[g+1]),
            .at_bound (at_bound[g])
        );
    end

    assign start_val = mode_selection ? lim_c : '0;

    // With every nibble a legal BCD digit, packed BCD orders exactly like
    // an unsigned binary vector, so a plain magnitude compare suffices.
    assign above_lim = (count > lim_c);
    // Up: count >= L, built from the per-digit equality and the compare.
    assign up_wrap   = (&at_bound) | above_lim;
    // Down: a borrow rippling out of the top digit means count was zero.
    assign down_zero = chain[DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CNT_IDLE;
            count   <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (pb_clear) begin
                state   <= CNT_IDLE;
                count   <= start_val;
                running <= 1'b0;
            end else if (pb_start) begin
                // A tick coinciding with pb_start is deliberately dropped.
                if (state == CNT_RUN) begin
                    state   <= CNT_PAUSE;
                    running <= 1'b0;
                end else begin
                    if (state == CNT_IDLE) count <= start_val;
                    state   <= CNT_RUN;
                    running <= 1'b1;
                end
            end else begin
                case (state)
                    CNT_IDLE: count <= start_val;
                    CNT_RUN: begin
                        if (tick) begin
                            if (!mode_selection) begin
                                if (up_wrap) begin
                                    count <= '0;
                                    wrap  <= 1'b1;
                                end else begin
                                    count <= step_val;
                                end
                            end else begin
                                if (down_zero) begin
                                    count <= lim_c;
                                    wrap  <= 1'b1;
                                end else if (above_lim) begin
                                    // Saturate back into range, not a wrap.
                                    count <= lim_c;
                                end else begin
                                    count <= step_val;
                                end
                            end
                        end
                    end
                    CNT_PAUSE: ;
                    default: begin
                        state   <= CNT_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
